redmule_cfg_regfile: RTL
========================

Name: redmule_cfg_regfile

Overview:
- Memory-mapped configuration slave directly downstream of the instruction decoder.
- Receives the decoder's cfg_req write burst into six shadow registers (0x40–0x54).
- On a write to the trigger address (0x00), snapshots the shadow registers into a small job queue.
- Presents queued jobs to the RedMulE scheduler/controller via valid/ready, and returns cfg_complete back to the decoder to throttle further triggers.

Parameters:
- SysDataWidth, 32, config data width.
- NumCfgRegs, 6, number of shadow registers (X ptr, W ptr, Z ptr, M/K, N, arith instr).
- JobDepth, 2, job queue entries (power of 2, ≥1).
- IdWidth, 8, request id width carried in req.id and rsp.r_id.
- redmule_ctrl_req_t, logic, request struct with fields req, wen, be, add, data, id.
- redmule_ctrl_rsp_t, logic, response struct with fields gnt, r_valid, r_data, r_id.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- clear_i  in  1  synchronous soft clear.
- cfg_req_i  in  redmule_ctrl_req_t  config request.
- cfg_rsp_o  out  redmule_ctrl_rsp_t  config response.
- cfg_complete_o  out  1  queue can accept a trigger (count < JobDepth).
- job_valid_o  out  1  head job available.
- job_ready_i  in  1  controller consumes head job.
- job_o  out  redmule_job_t  head job contents.
- busy_o  out  1  queue non-empty or read response pending.

Behaviour:
- Clock/reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values:
  - Shadow registers = 0; queue empty (count = 0, pointers = 0).
  - cfg_rsp_o = '0; job_valid_o = 0; job_o = '0.
  - cfg_complete_o = 1; busy_o = 0.
- Write encoding: wen = 0 is a write, wen = 1 is a read.
- Address map (byte addresses; bits above [7:0] ignored, add[1:0] ignored):
  - 0x00 TRIGGER: write only; data ignored; pushes a job.
  - 0x04 STATUS: read only; returns {count, cfg_complete, job_valid} in the low bits, zero elsewhere.
  - 0x40 + 4*i, i = 0..NumCfgRegs-1: shadow register i, read/write.
  - Any other address: write is granted and dropped; read returns 0.
- Grant (combinational from cfg_req_i and state):
  - gnt = req for every access, except a TRIGGER write when count == JobDepth, which gets gnt = 0.
  - A stalled requester holds the request until granted.
  - No combinational path from job_ready_i to gnt.
- Shadow write: on req & gnt & !wen, shadow[i] is updated byte-wise per be; the value is visible the next cycle.
- Read response:
  - One cycle after req & gnt & wen, r_valid = 1 for exactly one cycle, with r_data and r_id = captured id.
  - r_valid = 0 otherwise.
  - Back-to-back reads are supported, one per cycle.
- Trigger push: on a granted TRIGGER write, the current shadow contents (including a same-cycle shadow write? not possible, single port) are written into entry wr_ptr; wr_ptr increments modulo JobDepth and count increments.
- Shadow registers are not cleared by a trigger; consecutive jobs may reuse fields.
- Pop: when job_valid_o & job_ready_i, rd_ptr increments modulo JobDepth and count decrements.
- Simultaneous push and pop: count unchanged and both pointers advance. Not possible when full, because the push is stalled.
- Job output:
  - job_valid_o = (count != 0).
  - job_o = entry[rd_ptr] (registered array read, no extra latency).
  - job_o is stable while valid and not ready.
- job_o field mapping:
  - x_addr = shadow0, w_addr = shadow1, z_addr = shadow2.
  - m = shadow3[15:0], k = shadow3[31:16], n = shadow4[15:0].
  - arith = shadow5 (full instruction word; op/format decoded downstream).
- cfg_complete_o = (count < JobDepth), registered-state derived. It is asserted during reset-exit idle.
- busy_o = job_valid_o | pending read response.
- clear_i:
  - Empties the queue, zeroes the shadow registers, drops any pending r_valid, and drives gnt = 0 that cycle.
  - clear_i has priority over simultaneous push and pop.
- Reset mid-burst: all state returns to reset values immediately (async). Partial shadow contents are lost.

Decomposition:
- Add the following to redmule_pkg:
  - redmule_job_t struct (x_addr, w_addr, z_addr [31:0]; m, k, n [15:0]; arith [31:0]).
  - Localparams REDMULE_TRIGGER_OFFS = 'h00, REDMULE_STATUS_OFFS = 'h04, REDMULE_SHADOW_BASE = 'h40.
- One sub-module: redmule_job_fifo (parameters type and depth; push/pop/full/empty/count/clear). The register decode and response logic stay in the top.

Test Plan:
- Write 0x40..0x54 with 0x1000, 0x2000, 0x3000, 0x0020_0010, 0x30, 0x0000_420B, then write 0x00 → job_valid_o = 1 the next cycle; job_o has x = 0x1000, m = 0x10, k = 0x20, n = 0x30, arith = 0x420B; cfg_complete_o stays 1.
- Three triggers with job_ready_i = 0 → first two granted; third has gnt = 0 and cfg_complete_o = 0. Pulse job_ready_i one cycle → third is granted the next cycle and count reaches 2.
- Read 0x44 with id 0x5A after writing 0xDEADBEEF with be = 0b0101 over 0 → r_valid one cycle later, r_data = 0x00AD00EF, r_id = 0x5A.
- Push and pop in the same cycle at count = 1 → count stays 1 and job_o advances to the new entry.
- Assert clear_i with 2 queued jobs and a read in flight → next cycle job_valid_o = 0, r_valid = 0, shadow reads return 0.
- Assert rst_ni low mid-burst → all outputs at reset values; a write to 0x48 afterwards works normally.

Source files
------------

// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE configuration slave: bus request/response structs, job descriptor, address map.
// Pure declarations; no logic and no state.
package redmule_pkg;

   localparam int unsigned SysDataWidth = 32;
   localparam int unsigned IdWidth      = 8;

   localparam logic [7:0] REDMULE_TRIGGER_OFFS = 8'h00;
   localparam logic [7:0] REDMULE_STATUS_OFFS  = 8'h04;
   localparam logic [7:0] REDMULE_SHADOW_BASE  = 8'h40;

   typedef struct packed {
      logic                        req;
      logic                        wen;
      logic [SysDataWidth/8-1:0]   be;
      logic [SysDataWidth-1:0]     add;
      logic [SysDataWidth-1:0]     data;
      logic [IdWidth-1:0]          id;
   } redmule_ctrl_req_t;

   typedef struct packed {
      logic                        gnt;
      logic                        r_valid;
      logic [SysDataWidth-1:0]     r_data;
      logic [IdWidth-1:0]          r_id;
   } redmule_ctrl_rsp_t;

   typedef struct packed {
      logic [31:0] x_addr;
      logic [31:0] w_addr;
      logic [31:0] z_addr;
      logic [15:0] m;
      logic [15:0] k;
      logic [15:0] n;
      logic [31:0] arith;
   } redmule_job_t;

endpackage

// File: rtl/redmule_job_fifo.sv
// Small job queue; head is the registered entry at rd_ptr, so a push is visible at the head one cycle later.
// Pushes while full and pops while empty are ignored; clear empties the queue and wins over push/pop.
module redmule_job_fifo #(
   parameter type         T     = logic,
   parameter int unsigned Depth = 2,
   localparam int unsigned CntW = $clog2(Depth + 1),
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            push,
   input  T                push_data,
   input  logic            pop,
   output T                head,
   output logic            full,
   output logic            empty,
   output logic [CntW-1:0] count
);

   T                mem [Depth];
   logic [PtrW-1:0] wr_ptr;
   logic [PtrW-1:0] rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CntW'(Depth));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CntW'(1);
            2'b01:   count <= count - CntW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/redmule_cfg_regfile.sv
// Config slave: shadow registers written by the decoder, snapshotted into a job queue on a TRIGGER write.
// Reads answer one cycle after grant; TRIGGER is stalled (gnt=0) while the queue is full.
module redmule_cfg_regfile
   import redmule_pkg::*;
#(
   parameter int unsigned NumCfgRegs = 6,
   parameter int unsigned JobDepth   = 2,
   localparam int unsigned CntW      = $clog2(JobDepth + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  redmule_ctrl_req_t cfg_req_i,
   output redmule_ctrl_rsp_t cfg_rsp_o,
   output logic              cfg_complete_o,
   output logic              job_valid_o,
   input  logic              job_ready_i,
   output redmule_job_t      job_o,
   output logic              busy_o
);

   localparam logic [5:0] TrigWord   = REDMULE_TRIGGER_OFFS[7:2];
   localparam logic [5:0] StatusWord = REDMULE_STATUS_OFFS[7:2];
   localparam logic [5:0] ShadowWord = REDMULE_SHADOW_BASE[7:2];
   localparam int unsigned NumBytes  = SysDataWidth / 8;

   logic [SysDataWidth-1:0] shadow [NumCfgRegs];
   logic [NumCfgRegs-1:0]   sel;
   logic [5:0]              word;
   logic                    is_trig;
   logic                    is_status;
   logic                    gnt;
   logic                    wr_en;
   logic                    rd_en;
   logic                    push;
   logic                    full;
   logic                    empty;
   logic [CntW-1:0]         count;
   logic [SysDataWidth-1:0] rdata;
   logic                    r_valid_q;
   logic [SysDataWidth-1:0] r_data_q;
   logic [IdWidth-1:0]      r_id_q;
   redmule_job_t            push_job;
   logic                    unused_addr;

   // Only the word offset within the low byte of the address selects a register.
   assign word        = cfg_req_i.add[7:2];
   assign unused_addr = ^{cfg_req_i.add[SysDataWidth-1:8], cfg_req_i.add[1:0]};
   assign is_trig     = (word == TrigWord);
   assign is_status   = (word == StatusWord);

   always_comb begin
      sel = '0;
      for (int unsigned i = 0; i < NumCfgRegs; i++) begin
         sel[i] = (word == ShadowWord + 6'(i));
      end
   end

   assign gnt   = cfg_req_i.req & ~clear_i & ~(is_trig & ~cfg_req_i.wen & full);
   assign wr_en = cfg_req_i.req & gnt & ~cfg_req_i.wen;
   assign rd_en = cfg_req_i.req & gnt & cfg_req_i.wen;
   assign push  = wr_en & is_trig;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow <= '{default: '0};
      end else if (clear_i) begin
         shadow <= '{default: '0};
      end else begin
         for (int unsigned i = 0; i < NumCfgRegs; i++) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
               if (wr_en && sel[i] && cfg_req_i.be[b]) begin
                  shadow[i][8*b +: 8] <= cfg_req_i.data[8*b +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (is_status) begin
         rdata = SysDataWidth'({count, ~full, ~empty});
      end
      for (int unsigned i = 0; i < NumCfgRegs; i++) begin
         if (sel[i]) begin
            rdata = shadow[i];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid_q <= 1'b0;
         r_data_q  <= '0;
         r_id_q    <= '0;
      end else if (clear_i) begin
         r_valid_q <= 1'b0;
      end else begin
         r_valid_q <= rd_en;
         if (rd_en) begin
            r_data_q <= rdata;
            r_id_q   <= cfg_req_i.id;
         end
      end
   end

   always_comb begin
      cfg_rsp_o         = '0;
      cfg_rsp_o.gnt     = gnt;
      cfg_rsp_o.r_valid = r_valid_q;
      cfg_rsp_o.r_data  = r_data_q;
      cfg_rsp_o.r_id    = r_id_q;
   end

   always_comb begin
      push_job        = '0;
      push_job.x_addr = shadow[0];
      push_job.w_addr = shadow[1];
      push_job.z_addr = shadow[2];
      push_job.m      = shadow[3][15:0];
      push_job.k      = shadow[3][31:16];
      push_job.n      = shadow[4][15:0];
      push_job.arith  = shadow[5];
   end

   redmule_job_fifo #(
      .T     (redmule_job_t),
      .Depth (JobDepth)
   ) i_job_fifo (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .clear     (clear_i),
      .push      (push),
      .push_data (push_job),
      .pop       (job_ready_i),
      .head      (job_o),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   assign job_valid_o    = ~empty;
   assign cfg_complete_o = ~full;
   assign busy_o         = ~empty | r_valid_q;

endmodule
